// File: rtl/mmio_arbiter.sv
// Purpose: two-master round-robin (or fixed-priority) arbiter for the single I/O-unit register port.
// Latency: io_re/io_we one cycle after grant, ack two cycles after grant, one transaction per 3 cycles.
// Backpressure: requests are level-held; a losing master simply waits for the next IDLE, never dropped.
module mmio_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_glb,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_din,
    output logic              io_re,
    output logic              io_we,
    input  logic [DATA_W-1:0] io_dout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              cur_q;
    logic              last_q;
    logic              gnt_vld;
    logic              gnt_idx;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_din;

    always_ff @(posedge clk_glb) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_vld) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // On a tie, round-robin hands the port to whichever master did not go last.
    always_comb begin
        gnt_vld = m0_req | m1_req;
        gnt_idx = m1_req;
        if (m0_req && m1_req) begin
            if (FIXED_PRIO != 0) begin
                gnt_idx = 1'b1;
            end else begin
                gnt_idx = ~last_q;
            end
        end
        gnt_we   = gnt_idx ? m1_we   : m0_we;
        gnt_addr = gnt_idx ? m1_addr : m0_addr;
        gnt_din  = gnt_idx ? m1_din  : m0_din;
    end

    always_ff @(posedge clk_glb) begin
        if (!rstn) begin
            cur_q    <= 1'b0;
            last_q   <= 1'b1;
            io_addr  <= '0;
            io_din   <= '0;
            io_re    <= 1'b0;
            io_we    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        io_addr <= gnt_addr;
                        io_din  <= gnt_din;
                        io_we   <= gnt_we;
                        io_re   <= ~gnt_we;
                        cur_q   <= gnt_idx;
                    end
                end
                ST_ACCESS: begin
                    io_re  <= 1'b0;
                    io_we  <= 1'b0;
                    last_q <= cur_q;
                    // io_re is still high here only for reads; writes leave rdata alone.
                    if (io_re) begin
                        if (cur_q) m1_rdata <= io_dout;
                        else       m0_rdata <= io_dout;
                    end
                    if (cur_q) m1_ack <= 1'b1;
                    else       m0_ack <= 1'b1;
                end
                ST_RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                end
                default: begin
                    io_re <= 1'b0;
                    io_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench: round-robin instance (a_*) and fixed-priority instance (p_*) share all inputs.
module tb_mmio_arbiter;

    logic        clk_glb = 1'b0;
    logic        rstn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_din, m1_addr, m1_din, io_dout;

    logic        a_m0_ack, a_m1_ack, a_io_re, a_io_we;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_io_addr, a_io_din;
    logic        p_m0_ack, p_m1_ack, p_io_re, p_io_we;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_io_addr, p_io_din;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_glb = ~clk_glb;

    mmio_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
        .clk_glb(clk_glb), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .io_addr(a_io_addr), .io_din(a_io_din), .io_re(a_io_re), .io_we(a_io_we),
        .io_dout(io_dout)
    );

    mmio_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
        .clk_glb(clk_glb), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
        .io_addr(p_io_addr), .io_din(p_io_din), .io_re(p_io_re), .io_we(p_io_we),
        .io_dout(io_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_glb);
        #1;
    endtask

    initial begin
        int pulses;
        int n_ack;
        int order[4];
        int ack_cyc[4];
        int p_m0_n, p_m1_n;
        int re_cnt, ack_cnt;

        rstn = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_din = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_din = 0;
        io_dout = 0;
        step();
        step();
        check("rst_io_re",  {31'd0, a_io_re}, 32'd0);
        check("rst_io_we",  {31'd0, a_io_we}, 32'd0);
        check("rst_io_addr", a_io_addr, 32'd0);
        check("rst_io_din",  a_io_din, 32'd0);
        check("rst_ack",    {30'd0, a_m0_ack, a_m1_ack}, 32'd0);
        check("rst_rdata0", a_m0_rdata, 32'd0);
        check("rst_rdata1", a_m1_rdata, 32'd0);

        // single read by m0
        rstn = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h7f0C; io_dout = 32'd1;
        step();
        check("rd_t1_re",   {31'd0, a_io_re}, 32'd1);
        check("rd_t1_we",   {31'd0, a_io_we}, 32'd0);
        check("rd_t1_addr", a_io_addr, 32'h7f0C);
        check("rd_t1_ack",  {31'd0, a_m0_ack}, 32'd0);
        step();
        check("rd_t2_re",   {31'd0, a_io_re}, 32'd0);
        check("rd_t2_we",   {31'd0, a_io_we}, 32'd0);
        check("rd_t2_ack",  {31'd0, a_m0_ack}, 32'd1);
        check("rd_t2_rdata", a_m0_rdata, 32'd1);
        m0_req = 0;
        step();
        check("rd_t3_ack",  {31'd0, a_m0_ack}, 32'd0);
        check("rd_t3_re",   {31'd0, a_io_re}, 32'd0);

        // single write by m1
        m1_req = 1; m1_we = 1; m1_addr = 32'h7f08; m1_din = 32'h12345678;
        step();
        check("wr_t1_we",   {31'd0, a_io_we}, 32'd1);
        check("wr_t1_re",   {31'd0, a_io_re}, 32'd0);
        check("wr_t1_addr", a_io_addr, 32'h7f08);
        check("wr_t1_din",  a_io_din, 32'h12345678);
        step();
        check("wr_t2_we",   {31'd0, a_io_we}, 32'd0);
        check("wr_t2_ack",  {31'd0, a_m1_ack}, 32'd1);
        check("wr_t2_rdata1", a_m1_rdata, 32'd0);
        check("wr_t2_rdata0", a_m0_rdata, 32'd1);
        m1_req = 0;
        step();
        check("wr_t3_ack",  {31'd0, a_m1_ack}, 32'd0);

        // tie after reset, both requesting continuously
        rstn = 1'b0;
        m1_we = 0;
        step();
        rstn = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h100;
        m1_req = 1; m1_we = 0; m1_addr = 32'h200;
        io_dout = 32'd5;
        pulses = 0; n_ack = 0; p_m0_n = 0; p_m1_n = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            if (a_io_re || a_io_we) pulses++;
            if ((a_m0_ack || a_m1_ack) && n_ack < 4) begin
                order[n_ack]   = a_m1_ack ? 1 : 0;
                ack_cyc[n_ack] = cyc;
                n_ack++;
            end
            if (p_m0_ack) p_m0_n++;
            if (p_m1_ack) p_m1_n++;
        end
        check("rr_pulses", pulses, 32'd4);
        check("rr_n_ack",  n_ack, 32'd4);
        check("rr_order",  {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);
        check("rr_ackcyc", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0], ack_cyc[3][7:0]}, 32'h0205080B);
        check("rr_rdata0", a_m0_rdata, 32'd5);
        check("rr_rdata1", a_m1_rdata, 32'd5);
        check("fp_m1_grants", p_m1_n, 32'd4);
        check("fp_m0_grants", p_m0_n, 32'd0);

        // fixed priority: m1 drops, m0 granted at the next IDLE
        m1_req = 0;
        step();
        check("fp_m0_re",   {31'd0, p_io_re}, 32'd1);
        check("fp_m0_addr", p_io_addr, 32'h100);
        step();
        check("fp_m0_ack",  {31'd0, p_m0_ack}, 32'd1);
        check("fp_m0_rdata", p_m0_rdata, 32'd5);
        m0_req = 0;
        step();

        // exactly-once: req held until ack
        m0_req = 1; m0_we = 0; m0_addr = 32'h7f10; io_dout = 32'h77;
        re_cnt = 0; ack_cnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (a_io_re) begin
                re_cnt++;
                check("once_addr", a_io_addr, 32'h7f10);
            end
            if (a_m0_ack) begin
                ack_cnt++;
                m0_req = 0;
            end
        end
        check("once_re_cnt",  re_cnt, 32'd1);
        check("once_ack_cnt", ack_cnt, 32'd1);
        check("once_rdata",   a_m0_rdata, 32'h77);

        // reset asserted during ACCESS
        m0_req = 1; m0_we = 0; m0_addr = 32'h7f0C; io_dout = 32'h99;
        step();
        check("rsta_re", {31'd0, a_io_re}, 32'd1);
        rstn = 1'b0;
        m0_req = 0;
        step();
        check("rsta_re0",    {31'd0, a_io_re}, 32'd0);
        check("rsta_we0",    {31'd0, a_io_we}, 32'd0);
        check("rsta_ack",    {30'd0, a_m0_ack, a_m1_ack}, 32'd0);
        check("rsta_rdata0", a_m0_rdata, 32'd0);
        check("rsta_rdata1", a_m1_rdata, 32'd0);
        rstn = 1'b1;
        step();
        check("rsta_noack",  {30'd0, a_m0_ack, a_m1_ack}, 32'd0);
        m0_req = 1; m0_addr = 32'h300;
        m1_req = 1; m1_addr = 32'h400; m1_we = 0;
        step();
        check("rsta_tie_addr", a_io_addr, 32'h300);
        check("rsta_tie_re",   {31'd0, a_io_re}, 32'd1);
        step();
        check("rsta_tie_ack",  {30'd0, a_m0_ack, a_m1_ack}, 32'd2);
        m0_req = 0; m1_req = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master round-robin arbiter that shares the single I/O-unit register port (addr/din/re/we/dout) between the CPU data-memory path (master 0) and the debug unit (master 1). It serialises accesses so that the I/O unit sees exactly one registered access cycle per transaction. This guarantees exactly-once side effects, such as the swx_vld clear on a swx_data read and the seg_rdy clear on a seg_data write. It sits between the CPU/debug-unit bus decode and the I/O unit.

## Interface
- ADDR_W, 32, address width of masters and I/O port
- DATA_W, 32, data width
- FIXED_PRIO, 0, 1 = master 1 always wins ties (debug-priority mode); 0 = round-robin
- clk_glb  in  1  single clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- m0_req / m1_req  in  1  request, level; held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  ADDR_W  register address; stable while req high
- m0_din / m1_din  in  DATA_W  write data; stable while req high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_W  read data, valid from ack cycle, held until that master's next ack
- io_addr  out  ADDR_W  to I/O unit, registered
- io_din  out  DATA_W  to I/O unit, registered
- io_re / io_we  out  1  to I/O unit, registered, high for exactly one cycle per transaction
- io_dout  in  DATA_W  combinational read data from I/O unit

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If neither request is high, stay in IDLE. io_re = io_we = 0, and io_addr/io_din hold their last values.
  - If one request is high, grant it.
  - If both are high:
    - FIXED_PRIO=0: grant the master that is not `last`.
    - FIXED_PRIO=1: grant master 1.
  - On a grant, at the edge: load io_addr/io_din from the winner, set io_we = winner_we and io_re = ~winner_we, store the grant index in `cur`, and go to ACCESS.
- ACCESS (one cycle): the I/O unit sees the access.
  - At the edge, clear io_re/io_we.
  - If the access is a read, capture io_dout into m[cur]_rdata.
  - Set m[cur]_ack = 1, set `last` <= cur, and go to RESP.
- RESP (one cycle): m[cur]_ack high. At the edge, clear the ack and go to IDLE.
  - A master must drop or change req in the cycle after seeing ack.
  - req sampled in IDLE is treated as a new request.
- Writes leave m*_rdata unchanged.
- The non-granted master's req is ignored until IDLE. It is never lost, only delayed.
- Address decode, width checks and value checks are not performed here. Addresses pass through unmodified.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so master 0 wins the first tie; `cur` = 0.
  - io_re = io_we = 0.
  - io_addr = io_din = 0; m0_rdata = m1_rdata = 0.
  - m0_ack = m1_ack = 0.
- Latency, with req high in IDLE cycle T:
  - io_re/io_we high in T+1.
  - ack high in T+2.
  - Next grant no earlier than T+3.
  - Peak rate: one transaction per 3 cycles.
- Simultaneous requests in round-robin mode alternate strictly: 0, 1, 0, 1, … With continuous requests from both masters, neither waits more than one transaction.
- A req that rises during ACCESS or RESP is first considered in the following IDLE cycle.
- Reset mid-operation:
  - Reset asserted during ACCESS: the I/O access in that cycle still occurs, because the outputs are already registered. At the edge, all state returns to reset values and no ack is issued.
  - Reset asserted during RESP: the ack is cut at the edge.
- Reset has priority over all transitions.

## Test plan
- Single read: m0 reads 0x7f0C with io_dout = 1.
  - Required: io_re high for exactly 1 cycle (T+1); m0_ack at T+2; m0_rdata = 1; io_we never high.
- Single write: m1 writes 0x7f08 with din 0x12345678.
  - Required: io_addr = 0x7f08, io_din = 0x12345678, io_we high for 1 cycle; m1_ack at T+2; m1_rdata unchanged.
- Tie after reset, FIXED_PRIO=0, both requesting continuously:
  - Required grant order 0, 1, 0, 1.
  - Each ack 3 cycles apart.
  - Total of 4 io_re/io_we pulses in 12 cycles.
- FIXED_PRIO=1, both requesting continuously for 3 transactions: all 3 grants go to master 1.
  - Then drop m1_req: master 0 is granted at the next IDLE.
- Exactly-once side effect:
  - Stimulus: m0 reads 0x7f10 while m0_req is held high until ack.
  - Required: exactly one io_re cycle per ack; an io_re count of 2 for one request fails.
- Reset asserted during ACCESS:
  - Required: no ack; next cycle io_re = io_we = 0, state IDLE, rdata = 0.
  - A subsequent tie is won by master 0.
